led_show_sequencer: RTL and testbench

- Controller that sequences the 8-bit LED bank through four display modes: rotate-left, rotate-right, bounce, blink.
- Each mode runs for a fixed number of steps.
- All logic runs on the board clock. Step timing comes from an internal tick-enable divider, not a derived clock.
- Sits between the board switches and the LED pins. It is the successor controller to the single-pattern rotator.

---
 rtl/led_show_sequencer_pkg.sv | 33 +++
 rtl/led_show_sequencer_if.sv | 12 +
 rtl/led_show_sequencer_tick_gen.sv | 30 +++
 rtl/led_show_sequencer.sv | 103 ++++++++++
 tb/tb_led_show_sequencer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/led_show_sequencer_pkg.sv
// Shared encodings for the LED show sequencer: display modes, bounce direction
// and the pattern each mode starts from.
package led_show_pkg;

    typedef enum logic [1:0] {
        MODE_ROT_L  = 2'd0,
        MODE_ROT_R  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    localparam logic [7:0] ENTRY_ROT_L  = 8'h01;
    localparam logic [7:0] ENTRY_ROT_R  = 8'h80;
    localparam logic [7:0] ENTRY_BOUNCE = 8'h01;
    localparam logic [7:0] ENTRY_BLINK  = 8'hAA;

    function automatic logic [7:0] entry_pattern(input mode_e m);
        logic [7:0] pat;
        case (m)
            MODE_ROT_L:  pat = ENTRY_ROT_L;
            MODE_ROT_R:  pat = ENTRY_ROT_R;
            MODE_BOUNCE: pat = ENTRY_BOUNCE;
            default:     pat = ENTRY_BLINK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/led_show_sequencer_if.sv
// Switch-side controls and LED-side status of the show sequencer.
interface led_show_sequencer_if;
    logic       run;
    logic       mode_lock;
    logic [7:0] led;
    logic [1:0] mode;
    logic       tick;
    logic       mode_done;

    modport master (output run, mode_lock, input led, mode, tick, mode_done);
    modport slave  (input run, mode_lock, output led, mode, tick, mode_done);
endinterface

// File: rtl/led_show_sequencer_tick_gen.sv
// Step-tick enable divider: one-cycle tick every TICK_DIV running cycles,
// count frozen while run is low.
module tick_gen #(
    parameter int TICK_DIV = 25000000
) (
    input  logic CLK,
    input  logic rst,
    input  logic run,
    output logic tick
);
    localparam int DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    logic [DW-1:0] div_cnt_reg;
    logic          tick_reg;

    always_ff @(posedge CLK) begin
        if (rst) begin
            div_cnt_reg <= '0;
            tick_reg    <= 1'b0;
        end else if (run) begin
            tick_reg    <= (div_cnt_reg == DIV_LAST);
            div_cnt_reg <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + DW'(1);
        end else begin
            tick_reg    <= 1'b0;
        end
    end

    assign tick = tick_reg;
endmodule

// File: rtl/led_show_sequencer.sv
// Four-mode LED show: rotate-left, rotate-right, bounce, blink, each held for
// STEPS_PER_MODE ticks unless mode_lock pins the current mode.
module led_show_sequencer
    import led_show_pkg::*;
#(
    parameter int TICK_DIV       = 25000000,
    parameter int STEPS_PER_MODE = 16
) (
    input  logic                 CLK,
    input  logic                 rst,
    led_show_sequencer_if.slave  bus
);
    localparam int SW = (STEPS_PER_MODE > 1) ? $clog2(STEPS_PER_MODE) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEPS_PER_MODE - 1);

    logic          tick;
    logic          step_en;
    logic          last_step;
    logic [7:0]    led_reg, led_next;
    mode_e         mode_reg, mode_next;
    dir_e          dir_reg, dir_next;
    logic [SW-1:0] step_cnt_reg, step_cnt_next;
    logic [7:0]    rot_l, rot_r;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .CLK  (CLK),
        .rst  (rst),
        .run  (bus.run),
        .tick (tick)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rot
            assign rot_l[gi] = led_reg[(gi + 7) % 8];
            assign rot_r[gi] = led_reg[(gi + 1) % 8];
        end
    endgenerate

    // A tick only counts if run is still high on the edge that consumes it.
    assign step_en   = tick && bus.run;
    assign last_step = (step_cnt_reg == STEP_LAST);

    always_ff @(posedge CLK) begin
        if (rst) begin
            led_reg      <= ENTRY_ROT_L;
            mode_reg     <= MODE_ROT_L;
            dir_reg      <= DIR_LEFT;
            step_cnt_reg <= '0;
        end else begin
            led_reg      <= led_next;
            mode_reg     <= mode_next;
            dir_reg      <= dir_next;
            step_cnt_reg <= step_cnt_next;
        end
    end

    always_comb begin
        led_next      = led_reg;
        mode_next     = mode_reg;
        dir_next      = dir_reg;
        step_cnt_next = step_cnt_reg;
        if (step_en) begin
            step_cnt_next = last_step ? '0 : step_cnt_reg + SW'(1);
            if (last_step && !bus.mode_lock) begin
                mode_next = mode_e'(mode_reg + 2'd1);
                led_next  = entry_pattern(mode_next);
                dir_next  = DIR_LEFT;
            end else begin
                case (mode_reg)
                    MODE_ROT_L: led_next = rot_l;
                    MODE_ROT_R: led_next = rot_r;
                    MODE_BOUNCE: begin
                        // Reflect at the ends so the end bit is shown exactly once.
                        if (dir_reg == DIR_LEFT) begin
                            if (led_reg == 8'h80) begin
                                dir_next = DIR_RIGHT;
                                led_next = 8'h40;
                            end else begin
                                led_next = led_reg << 1;
                            end
                        end else begin
                            if (led_reg == 8'h01) begin
                                dir_next = DIR_LEFT;
                                led_next = 8'h02;
                            end else begin
                                led_next = led_reg >> 1;
                            end
                        end
                    end
                    default: led_next = ~led_reg;
                endcase
            end
        end
    end

    always_comb begin
        bus.led       = led_reg;
        bus.mode      = mode_reg;
        bus.tick      = tick;
        bus.mode_done = tick && last_step;
    end
endmodule

// File: tb/tb_led_show_sequencer.sv
// Directed bench for led_show_sequencer with a small behavioural show model
// feeding an expectation queue that is drained as ticks appear.
module tb_led_show_sequencer;
    localparam int TICK_DIV = 4;
    localparam int STEPS    = 4;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    always #5 CLK = ~CLK;

    led_show_sequencer_if bus ();

    led_show_sequencer #(.TICK_DIV(TICK_DIV), .STEPS_PER_MODE(STEPS)) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] led;
        logic [1:0] mode;
        logic       done;
        int         gap;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_led;
    int m_mode, m_step, m_pos, m_dir;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_led  = 8'h01;
        m_mode = 0;
        m_step = 0;
        m_pos  = 0;
        m_dir  = 1;
    endtask

    // Bounce is modelled as a bit position walking between 0 and 7.
    task automatic model_step(input bit lock, output bit done);
        done   = (m_step == STEPS - 1);
        m_step = done ? 0 : m_step + 1;
        if (done && !lock) begin
            m_mode = (m_mode + 1) % 4;
            case (m_mode)
                0: m_led = 8'h01;
                1: m_led = 8'h80;
                2: begin m_pos = 0; m_dir = 1; m_led = 8'h01; end
                default: m_led = 8'hAA;
            endcase
        end else begin
            case (m_mode)
                0: m_led = (m_led << 1) | (m_led >> 7);
                1: m_led = (m_led >> 1) | (m_led << 7);
                2: begin
                    if (m_pos + m_dir > 7 || m_pos + m_dir < 0) m_dir = -m_dir;
                    m_pos = m_pos + m_dir;
                    m_led = 8'(1 << m_pos);
                end
                default: m_led = ~m_led;
            endcase
        end
    endtask

    task automatic push_steps(input int n, input int first_gap);
        exp_t e;
        bit d;
        for (int i = 0; i < n; i++) begin
            model_step(bus.mode_lock, d);
            e.led  = m_led;
            e.mode = 2'(m_mode);
            e.done = d;
            e.gap  = (i == 0) ? first_gap : TICK_DIV - 1;
            sb.push_back(e);
        end
    endtask

    task automatic wait_tick(output int cyc);
        cyc = 0;
        do begin
            @(negedge CLK);
            cyc++;
        end while (bus.tick !== 1'b1 && cyc < 40);
    endtask

    task automatic consume(input int n, input string tag);
        exp_t e;
        int cyc;
        for (int i = 0; i < n; i++) begin
            wait_tick(cyc);
            e = sb.pop_front();
            check($sformatf("%s[%0d]_gap", tag, i), cyc, e.gap);
            check($sformatf("%s[%0d]_done", tag, i), bus.mode_done, e.done);
            @(negedge CLK);
            check($sformatf("%s[%0d]_led", tag, i), bus.led, e.led);
            check($sformatf("%s[%0d]_mode", tag, i), bus.mode, e.mode);
            check($sformatf("%s[%0d]_strobe", tag, i), {bus.tick, bus.mode_done}, 0);
            $display("step %s[%0d] led=%02h mode=%0d done=%0b", tag, i, bus.led, bus.mode, e.done);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bus.run       = 1'b0;
        bus.mode_lock = 1'b0;
        rst           = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_led", bus.led, 8'h01);
        check("rst_mode", bus.mode, 0);
        check("rst_tick", bus.tick, 0);
        check("rst_done", bus.mode_done, 0);

        // Full show cycle through all four modes.
        rst = 1'b0;
        model_reset();
        bus.run = 1'b1;
        push_steps(16, TICK_DIV);
        consume(16, "cycle");
        check("cycle_end_led", bus.led, 8'h01);
        check("cycle_end_mode", bus.mode, 0);

        // Freeze mid-period with div_cnt at 2; resume must finish the period.
        @(negedge CLK);
        bus.run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check($sformatf("frz[%0d]_tick", i), bus.tick, 0);
            check($sformatf("frz[%0d]_led", i), bus.led, m_led);
            check($sformatf("frz[%0d]_mode", i), bus.mode, 2'(m_mode));
        end
        bus.run = 1'b1;
        push_steps(1, 2);
        consume(1, "resume");
        push_steps(2, TICK_DIV - 1);
        consume(2, "rotl");

        // Drop run during the final tick of ROT_L: no update may happen.
        wait_tick(cyc);
        check("drop_gap", cyc, TICK_DIV - 1);
        bus.run = 1'b0;
        @(negedge CLK);
        check("drop_tick", bus.tick, 0);
        check("drop_led", bus.led, m_led);
        check("drop_mode", bus.mode, 2'(m_mode));
        bus.run = 1'b1;
        push_steps(1, TICK_DIV);
        consume(1, "after_drop");

        // Lock ROT_R for 12 ticks.
        bus.mode_lock = 1'b1;
        push_steps(12, TICK_DIV - 1);
        consume(12, "lock_rotr");
        bus.mode_lock = 1'b0;
        push_steps(4, TICK_DIV - 1);
        consume(4, "to_bounce");

        // Lock BOUNCE long enough to reflect at both ends.
        bus.mode_lock = 1'b1;
        push_steps(18, TICK_DIV - 1);
        consume(18, "bounce");
        bus.mode_lock = 1'b0;
        push_steps(3, TICK_DIV - 1);
        consume(3, "to_blink");

        // Reset in the middle of BLINK.
        @(negedge CLK);
        rst = 1'b1;
        @(negedge CLK);
        check("rst2_led", bus.led, 8'h01);
        check("rst2_mode", bus.mode, 0);
        check("rst2_tick", bus.tick, 0);
        check("rst2_done", bus.mode_done, 0);
        rst = 1'b0;
        model_reset();
        push_steps(4, TICK_DIV);
        consume(4, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
